player_motion: RTL and testbench

Per-tick player kinematics engine. It replaces the ad-hoc X-only update in the top level with parametrised horizontal walking, screen-edge clamping, a jump/gravity vertical state machine, pause hold and an encoded animation state. It is clocked by the 25 Hz GAME_clk. It sits between keyboard_input and image_renderer: it drives playerX, playerY and player_state.

---
 rtl/player_pkg.sv | 17 +
 rtl/player_vertical_fsm.sv | 70 +++++++
 rtl/player_motion.sv | 73 +++++++
 tb/tb_player_motion.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// player_pkg: shared state codes and ground-line helper for the player motion engine.
package player_pkg;
    typedef enum logic [1:0] {
        V_GROUNDED = 2'd0,
        V_RISING   = 2'd1,
        V_FALLING  = 2'd2
    } vstate_t;
    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_WALK    = 2'd1,
        PS_RISING  = 2'd2,
        PS_FALLING = 2'd3
    } pstate_t;
    function automatic int ground_y(input int screen_h, input int size_y);
        return screen_h - size_y;
    endfunction
endpackage

// File: rtl/player_vertical_fsm.sv
// player_vertical_fsm: jump/gravity state machine owning vertical velocity and sprite top edge.
module player_vertical_fsm
    import player_pkg::*;
#(
    parameter int SCREEN_H      = 480,
    parameter int PLAYER_SIZE_Y = 42,
    parameter int JUMP_V0       = 12,
    parameter int GRAVITY       = 1,
    parameter int MAX_FALL      = 15,
    parameter int POS_W         = 16
) (
    input  logic             GAME_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             jump_edge,
    output logic [POS_W-1:0] y,
    output vstate_t          state_nxt
);
    localparam logic [POS_W:0] GY = (POS_W+1)'(ground_y(SCREEN_H, PLAYER_SIZE_Y));
    localparam logic [POS_W:0] V0 = (POS_W+1)'(JUMP_V0);
    localparam logic [POS_W:0] G  = (POS_W+1)'(GRAVITY);
    localparam logic [POS_W:0] MF = (POS_W+1)'(MAX_FALL);
    vstate_t          state;
    logic [POS_W-1:0] y_q, y_n;
    logic [POS_W:0]   vel_q, vel_n, vel_inc, y_ext, y_fall;
    always_comb begin
        state_nxt = state;
        y_n       = y_q;
        vel_n     = vel_q;
        y_ext     = {1'b0, y_q};
        vel_inc   = (vel_q + G >= MF) ? MF : vel_q + G;
        y_fall    = y_ext + vel_inc;
        if (en) begin
            case (state)
                V_GROUNDED: begin
                    state_nxt = jump_edge ? V_RISING : V_GROUNDED;
                    vel_n     = jump_edge ? V0 : vel_q;
                end
                V_RISING: begin
                    // reaching the top of the screen ends the rise early
                    y_n       = (vel_q >= y_ext) ? '0 : POS_W'(y_ext - vel_q);
                    state_nxt = (vel_q <= G || vel_q >= y_ext) ? V_FALLING : V_RISING;
                    vel_n     = (vel_q <= G || vel_q >= y_ext) ? '0 : vel_q - G;
                end
                V_FALLING: begin
                    y_n       = (y_fall >= GY) ? POS_W'(GY) : POS_W'(y_fall);
                    vel_n     = (y_fall >= GY) ? '0 : vel_inc;
                    state_nxt = (y_fall >= GY) ? V_GROUNDED : V_FALLING;
                end
                default: begin
                    state_nxt = V_GROUNDED;
                    y_n       = POS_W'(GY);
                    vel_n     = '0;
                end
            endcase
        end
    end
    always_ff @(posedge GAME_clk or posedge rst) begin
        if (rst) begin
            state <= V_GROUNDED;
            y_q   <= POS_W'(GY);
            vel_q <= '0;
        end else begin
            state <= state_nxt;
            y_q   <= y_n;
            vel_q <= vel_n;
        end
    end
    assign y = y_q;
endmodule

// File: rtl/player_motion.sv
// player_motion: per-tick player kinematics: clamped walking, jump/gravity, pause hold, animation state.
module player_motion
    import player_pkg::*;
#(
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int PLAYER_SIZE_X = 37,
    parameter int PLAYER_SIZE_Y = 42,
    parameter int WALK_STEP     = 5,
    parameter int JUMP_V0       = 12,
    parameter int GRAVITY       = 1,
    parameter int MAX_FALL      = 15,
    parameter int POS_W         = 16
) (
    input  logic             GAME_clk,
    input  logic             rst,
    input  logic             direction,
    input  logic             move,
    input  logic             jump,
    input  logic             pause,
    output logic [POS_W-1:0] playerX,
    output logic [POS_W-1:0] playerY,
    output logic [1:0]       player_state,
    output logic             on_ground
);
    localparam logic [POS_W:0] X_MAX = (POS_W+1)'(SCREEN_W - PLAYER_SIZE_X);
    localparam logic [POS_W:0] STEP  = (POS_W+1)'(WALK_STEP);
    logic             jump_prev, jump_edge;
    logic [POS_W:0]   x_ext, x_right, x_left;
    logic [POS_W-1:0] x_n;
    pstate_t          ps_n;
    vstate_t          v_nxt;
    // edges arriving on paused ticks are dropped, since jump_prev still advances
    assign jump_edge = jump & ~jump_prev & ~pause;
    always_comb begin
        x_ext   = {1'b0, playerX};
        x_right = (x_ext + STEP > X_MAX) ? X_MAX : x_ext + STEP;
        x_left  = (x_ext < STEP) ? {(POS_W+1){1'b0}} : x_ext - STEP;
        x_n     = !move ? playerX : direction ? POS_W'(x_right) : POS_W'(x_left);
        ps_n    = (v_nxt == V_GROUNDED) ? (move ? PS_WALK : PS_IDLE) :
                  (v_nxt == V_RISING) ? PS_RISING : PS_FALLING;
    end
    player_vertical_fsm #(
        .SCREEN_H     (SCREEN_H),
        .PLAYER_SIZE_Y(PLAYER_SIZE_Y),
        .JUMP_V0      (JUMP_V0),
        .GRAVITY      (GRAVITY),
        .MAX_FALL     (MAX_FALL),
        .POS_W        (POS_W)
    ) u_vert (
        .GAME_clk (GAME_clk),
        .rst      (rst),
        .en       (~pause),
        .jump_edge(jump_edge),
        .y        (playerY),
        .state_nxt(v_nxt)
    );
    always_ff @(posedge GAME_clk or posedge rst) begin
        if (rst) begin
            playerX      <= '0;
            player_state <= PS_IDLE;
            on_ground    <= 1'b1;
            jump_prev    <= 1'b0;
        end else begin
            jump_prev <= jump;
            if (!pause) begin
                playerX      <= x_n;
                player_state <= ps_n;
                on_ground    <= (v_nxt == V_GROUNDED);
            end
        end
    end
endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: directed stimulus with a signed-velocity physics model checked every tick.
module tb_player_motion;
    logic        GAME_clk, rst, direction, move, jump, pause;
    logic [15:0] playerX, playerY;
    logic [1:0]  player_state;
    logic        on_ground;
    int checks = 0;
    int failures = 0;
    int mx, my, mv, mps, mprev;
    bit air, mog;
    int ys [24] = '{426, 415, 405, 396, 388, 381, 375, 370, 366, 363, 361, 360,
                    361, 363, 366, 370, 375, 381, 388, 396, 405, 415, 426, 438};

    player_motion dut (
        .GAME_clk    (GAME_clk),
        .rst         (rst),
        .direction   (direction),
        .move        (move),
        .jump        (jump),
        .pause       (pause),
        .playerX     (playerX),
        .playerY     (playerY),
        .player_state(player_state),
        .on_ground   (on_ground)
    );

    initial GAME_clk = 0;
    always #5 GAME_clk = ~GAME_clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge GAME_clk);
        #1;
    endtask

    // physics model: y grows downward, velocity signed (negative = moving up)
    always @(posedge GAME_clk or posedge rst) begin
        if (rst) begin
            mx = 0; my = 438; mv = 0; air = 0; mps = 0; mog = 1; mprev = 0;
        end else begin
            if (!pause) begin
                if (move) mx = direction ? ((mx + 5 > 603) ? 603 : mx + 5) : ((mx < 5) ? 0 : mx - 5);
                if (!air) begin
                    if (jump && !mprev) begin air = 1; mv = -12; end
                end else if (mv < 0) begin
                    if (my + mv <= 0) begin my = 0; mv = 0; end
                    else begin my = my + mv; mv = (mv >= -1) ? 0 : mv + 1; end
                end else begin
                    mv = (mv + 1 > 15) ? 15 : mv + 1;
                    my = my + mv;
                    if (my >= 438) begin my = 438; mv = 0; air = 0; end
                end
                mps = !air ? (move ? 1 : 0) : (mv < 0 ? 2 : 3);
                mog = !air;
            end
            mprev = jump;
        end
    end

    always @(negedge GAME_clk) begin
        check("model_x", int'(playerX), mx);
        check("model_y", int'(playerY), my);
        check("model_state", int'(player_state), mps);
        check("model_on_ground", int'(on_ground), int'(mog));
    end

    initial begin
        rst = 1; direction = 0; move = 0; jump = 0; pause = 0;
        repeat (2) step();
        check("reset_x", int'(playerX), 0);
        check("reset_y", int'(playerY), 438);
        check("reset_state", int'(player_state), 0);
        check("reset_on_ground", int'(on_ground), 1);
        rst = 0;
        // walking right from the left edge
        move = 1; direction = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("walk_x", int'(playerX), 5 * i);
            check("walk_state", int'(player_state), 1);
            check("walk_y", int'(playerY), 438);
        end
        repeat (117) step();
        check("right_600", int'(playerX), 600);
        step();
        check("right_clamp", int'(playerX), 603);
        step();
        check("right_hold", int'(playerX), 603);
        direction = 0;
        repeat (120) step();
        check("left_3", int'(playerX), 3);
        step();
        check("left_clamp", int'(playerX), 0);
        move = 0;
        // single jump, exact trajectory
        jump = 1;
        step();
        check("launch_state", int'(player_state), 2);
        check("launch_y", int'(playerY), 438);
        check("launch_on_ground", int'(on_ground), 0);
        jump = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            check("traj_y", int'(playerY), ys[i]);
            if (i == 11) check("apex_state", int'(player_state), 3);
        end
        check("land_state", int'(player_state), 0);
        check("land_on_ground", int'(on_ground), 1);
        // held jump fires once
        jump = 1;
        repeat (40) step();
        check("held_on_ground", int'(on_ground), 1);
        check("held_y", int'(playerY), 438);
        jump = 0;
        step();
        jump = 1;
        step();
        jump = 0;
        repeat (5) step();
        jump = 1;
        step();
        jump = 0;
        repeat (17) step();
        check("midair_still_air", int'(on_ground), 0);
        step();
        check("midair_ignored_land", int'(on_ground), 1);
        check("midair_ignored_y", int'(playerY), 438);
        jump = 1;
        step();
        check("rejump_state", int'(player_state), 2);
        jump = 0;
        // pause mid-rise
        repeat (3) step();
        check("pre_pause_y", int'(playerY), 405);
        pause = 1; move = 1; direction = 1;
        for (int i = 0; i < 5; i++) begin
            jump = (i == 1 || i == 2);
            step();
            check("pause_y", int'(playerY), 405);
            check("pause_x", int'(playerX), 0);
            check("pause_state", int'(player_state), 2);
        end
        pause = 0; move = 0; jump = 0;
        step();
        check("resume_y", int'(playerY), 396);
        repeat (20) step();
        check("resume_land", int'(on_ground), 1);
        // edge on a grounded paused tick is discarded
        pause = 1; jump = 1;
        step();
        pause = 0;
        step();
        check("paused_edge_on_ground", int'(on_ground), 1);
        check("paused_edge_state", int'(player_state), 0);
        jump = 0;
        step();
        // async reset at apex
        jump = 1;
        step();
        jump = 0;
        repeat (12) step();
        check("apex_y", int'(playerY), 360);
        check("apex_falling", int'(player_state), 3);
        #1 rst = 1;
        #1;
        check("async_x", int'(playerX), 0);
        check("async_y", int'(playerY), 438);
        check("async_state", int'(player_state), 0);
        check("async_on_ground", int'(on_ground), 1);
        step();
        rst = 0;
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
